// File: rtl/cell3_vector_tester_if.sv
// Handshake and result bundle between a test controller and the 3-input cell vector tester.
// The tester owns STIM and the result signals; the controller owns commands and the cell response.
interface cell3_vector_tester_if;
  logic       START;
  logic       ABORT;
  logic [7:0] TRUTH;
  logic       Y_IN;
  logic [2:0] STIM;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [3:0] ERR_CNT;
  logic [7:0] FAIL_MAP;

  modport master (
    output START, ABORT, TRUTH, Y_IN,
    input  STIM, BUSY, DONE, PASS, ERR_CNT, FAIL_MAP
  );

  modport slave (
    input  START, ABORT, TRUTH, Y_IN,
    output STIM, BUSY, DONE, PASS, ERR_CNT, FAIL_MAP
  );
endinterface

// File: rtl/cell3_vector_tester.sv
// Exhaustive tester for a 3-input combinational cell: walks STIM through 0..7, lets each vector
// settle, samples Y_IN once per vector against a latched truth table and accumulates mismatches.
module cell3_vector_tester #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  cell3_vector_tester_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_truth;
  logic [2:0] r_stim;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_err_cnt;
  logic [7:0] r_fail_map;

  logic       w_mismatch;
  logic       w_last_vec;
  logic [3:0] w_err_inc;

  assign w_mismatch = (bus.Y_IN != r_truth[r_stim]);
  assign w_last_vec = (r_stim == 3'd7);
  // Only eight vectors exist, but saturate anyway so the count can never wrap.
  assign w_err_inc  = (r_err_cnt >= 4'd8) ? 4'd8 : r_err_cnt + 4'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_truth    <= 8'd0;
      r_stim     <= 3'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err_cnt  <= 4'd0;
      r_fail_map <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.START && !bus.ABORT) begin
            r_truth    <= bus.TRUTH;
            r_err_cnt  <= 4'd0;
            r_fail_map <= 8'd0;
            r_pass     <= 1'b0;
            r_stim     <= 3'd0;
            r_busy     <= 1'b1;
            r_cnt      <= 8'd0;
            r_state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (bus.ABORT) begin
            r_state <= IDLE;
            r_stim  <= 3'd0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_cnt   <= 8'd0;
          end else if (r_cnt == LAST_CNT) begin
            r_state <= SAMPLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        SAMPLE: begin
          if (bus.ABORT) begin
            r_state <= IDLE;
            r_stim  <= 3'd0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_cnt   <= 8'd0;
          end else begin
            if (w_mismatch) begin
              r_fail_map[r_stim] <= 1'b1;
              r_err_cnt          <= w_err_inc;
            end
            if (!w_last_vec) begin
              r_stim  <= r_stim + 3'd1;
              r_cnt   <= 8'd0;
              r_state <= SETTLE;
            end else begin
              // PASS must reflect the final sample taken on this same edge.
              r_pass  <= !w_mismatch && (r_err_cnt == 4'd0);
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_stim  <= 3'd0;
              r_cnt   <= 8'd0;
              r_state <= FINISH;
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.STIM     = r_stim;
  assign bus.BUSY     = r_busy;
  assign bus.DONE     = r_done;
  assign bus.PASS     = r_pass;
  assign bus.ERR_CNT  = r_err_cnt;
  assign bus.FAIL_MAP = r_fail_map;

endmodule

// File: doc/cell3_vector_tester.md
CELL3_VECTOR_TESTER -- requirements
Module: cell3_vector_tester

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, legal 1..255: cycles each stimulus vector is held before Y_IN is sampled.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port START  input  1  begin a run; accepted only in IDLE.
REQ-005 SHALL have port ABORT  input  1  terminate a run in progress.
REQ-006 SHALL have port TRUTH  input  8  expected cell output; bit i is the expected Y for stimulus index i.
REQ-007 SHALL have port Y_IN  input  1  output of the 3-input cell under test.
REQ-008 SHALL have port STIM  output  3  drives the cell inputs: STIM[2]=A, STIM[1]=B, STIM[0]=C.
REQ-009 SHALL have port BUSY  output  1  high from the first driven vector through the last sample.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse on run completion.
REQ-011 SHALL have port PASS  output  1  held result; high when the last completed run had zero mismatches.
REQ-012 SHALL have port ERR_CNT  output  4  mismatch count of the current or last run (0..8).
REQ-013 SHALL have port FAIL_MAP  output  8  bit i set when vector i mismatched.

Function
REQ-014 SHALL implement the states IDLE, SETTLE, SAMPLE and FINISH.
REQ-015 IDLE with START=1 and ABORT=0 SHALL register TRUTH, clear ERR_CNT, FAIL_MAP and PASS, set STIM=0 and BUSY=1, and go to SETTLE with the settle counter at 0.
REQ-016 SETTLE SHALL increment the settle counter each cycle and go to SAMPLE when the counter reaches SETTLE_CYCLES-1.
REQ-017 SAMPLE (one cycle) SHALL compare Y_IN with registered TRUTH[STIM] at the closing edge; on a mismatch it SHALL set FAIL_MAP[STIM] and increment ERR_CNT.
REQ-018 From SAMPLE with STIM<7, the block SHALL increment STIM and return to SETTLE with the counter at 0; with STIM=7 it SHALL go to FINISH.
REQ-019 Each vector SHALL be held for exactly SETTLE_CYCLES+1 cycles, so a run occupies 8*(SETTLE_CYCLES+1) cycles with BUSY=1.
REQ-020 FINISH (one cycle) SHALL assert DONE=1, BUSY=0 and STIM=0, set PASS=1 if and only if final ERR_CNT=0, then go to IDLE.
REQ-021 ERR_CNT and FAIL_MAP SHALL hold their values after a run until the next accepted START or reset.
REQ-022 START outside IDLE SHALL be ignored; a TRUTH change during a run SHALL have no effect.
REQ-023 ABORT=1 in SETTLE or SAMPLE SHALL, at the next edge, go to IDLE with STIM=0, BUSY=0 and PASS=0, with no DONE pulse and no compare in that cycle.
REQ-024 ABORT SHALL take priority over START in IDLE; ERR_CNT and FAIL_MAP SHALL keep their partial values after ABORT.
REQ-025 STIM SHALL change only at vector boundaries and SHALL equal 0 whenever BUSY=0.
REQ-026 ERR_CNT SHALL never exceed 8 and SHALL not wrap.

Reset
REQ-027 RST=1 SHALL, at the next edge and overriding all other inputs, force IDLE with STIM=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_MAP=0 and the settle counter at 0, including mid-run.
REQ-028 After RST deasserts, the block SHALL accept START on the first edge.

Verification
REQ-029 SETTLE_CYCLES=4, TRUTH=8'h01, Y_IN=~|STIM -> BUSY high for 40 cycles, DONE pulses once, then PASS=1, ERR_CNT=0, FAIL_MAP=8'h00.
REQ-030 TRUTH=8'h01, Y_IN stuck 0 -> ERR_CNT=1, FAIL_MAP=8'h01, PASS=0; with Y_IN stuck 1 -> ERR_CNT=7, FAIL_MAP=8'hFE, PASS=0.
REQ-031 SETTLE_CYCLES=1 -> each STIM value is held exactly 2 cycles, BUSY lasts 16 cycles, and STIM steps 0..7 in order.
REQ-032 ABORT while STIM=3 -> next cycle BUSY=0, STIM=0, no DONE; then START gives a full clean run with PASS=1.
REQ-033 RST while STIM=5 -> next cycle all outputs 0; START applied in the same cycle as RST is ignored.
REQ-034 START pulsed while BUSY, and TRUTH flipped to 8'hFE mid-run -> run unaffected, results checked against the original 8'h01.
